// File: rtl/countdown_timer_pkg.sv
// Shared types and default sizing for the countdown timer.
package countdown_timer_pkg;

    // Controller states: waiting for a load, or counting down.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Default count width and expiry-counter width.
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_EXP_CNT_W = 8;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-shot / periodic modes, hold, abort,
// a registered terminal-count pulse and a wrapping expiry counter.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int EXP_CNT_W = DEF_EXP_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [WIDTH-1:0]     load_value,
    input  logic                 load_periodic,
    input  logic                 hold,
    input  logic                 abort,
    output logic [WIDTH-1:0]     cnt_o,
    output logic                 busy,
    output logic                 expire,
    output logic [EXP_CNT_W-1:0] n_expired
);

    state_t             state;
    logic [WIDTH-1:0]   reload;
    logic               periodic;
    logic               accept;
    logic               at_terminal;

    assign load_ready  = (state == IDLE);
    assign busy        = (state == RUN);
    assign accept      = load_valid & load_ready;
    // The last counted cycle; anything at or below 1 ends the period so
    // the counter can never wrap below zero.
    assign at_terminal = (cnt_o <= WIDTH'(1));

    // Controller and datapath: load/reload mux, decrementer and expiry tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt_o     <= '0;
            reload    <= '0;
            periodic  <= 1'b0;
            expire    <= 1'b0;
            n_expired <= '0;
        end else begin
            expire <= 1'b0;
            case (state)
                IDLE: begin
                    // abort is ignored here; a pending load always wins.
                    if (accept) begin
                        reload   <= load_value;
                        periodic <= load_periodic;
                        cnt_o    <= load_value;
                        if (load_value == '0) begin
                            // Zero-length countdown expires immediately in either mode.
                            expire    <= 1'b1;
                            n_expired <= EXP_CNT_W'(1);
                            state     <= IDLE;
                        end else begin
                            n_expired <= '0;
                            state     <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        // Cancellation beats both hold and terminal count.
                        state <= IDLE;
                        cnt_o <= '0;
                    end else if (!hold) begin
                        if (at_terminal) begin
                            expire    <= 1'b1;
                            n_expired <= n_expired + EXP_CNT_W'(1);
                            if (periodic) begin
                                // Reload lands on the expiry cycle so the
                                // period is exactly 'reload' cycles.
                                cnt_o <= reload;
                            end else begin
                                cnt_o <= '0;
                                state <= IDLE;
                            end
                        end else begin
                            cnt_o <= cnt_o - WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed-vector bench for countdown_timer with a queued scoreboard.
module tb_countdown_timer;

    localparam int W  = 8;
    localparam int EW = 2;

    logic          clk;
    logic          reset;
    logic          load_valid;
    logic          load_ready;
    logic [W-1:0]  load_value;
    logic          load_periodic;
    logic          hold;
    logic          abort;
    logic [W-1:0]  cnt_o;
    logic          busy;
    logic          expire;
    logic [EW-1:0] n_expired;

    countdown_timer #(.WIDTH(W), .EXP_CNT_W(EW)) dut (
        .clk           (clk),
        .reset         (reset),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_value    (load_value),
        .load_periodic (load_periodic),
        .hold          (hold),
        .abort         (abort),
        .cnt_o         (cnt_o),
        .busy          (busy),
        .expire        (expire),
        .n_expired     (n_expired)
    );

    typedef struct {
        int            cyc;
        logic [W-1:0]  cnt;
        logic          busy;
        logic          expire;
        logic [EW-1:0] n;
    } exp_t;

    exp_t q[$];
    int   cycnt   = 0;
    int   n_check = 0;
    int   n_fail  = 0;
    logic done    = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycnt <= cycnt + 1;

    task automatic check(input string name, input int act, input int req);
        n_check++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cycnt, act, req);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [W-1:0] ec, input logic eb,
                                 input logic ee, input logic [EW-1:0] en);
        check({tag, ".cnt_o"},      int'(cnt_o),      int'(ec));
        check({tag, ".busy"},       int'(busy),       int'(eb));
        check({tag, ".expire"},     int'(expire),     int'(ee));
        check({tag, ".n_expired"},  int'(n_expired),  int'(en));
        check({tag, ".load_ready"}, int'(load_ready), int'(!eb));
    endtask

    task automatic push_exp(input logic [W-1:0] ec, input logic eb, input logic ee,
                            input logic [EW-1:0] en);
        exp_t e;
        e.cyc    = cycnt + 1;
        e.cnt    = ec;
        e.busy   = eb;
        e.expire = ee;
        e.n      = en;
        q.push_back(e);
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic lv, input logic [W-1:0] lval, input logic per,
                        input logic h, input logic ab,
                        input logic [W-1:0] ec, input logic eb, input logic ee,
                        input logic [EW-1:0] en);
        load_valid    = lv;
        load_value    = lval;
        load_periodic = per;
        hold          = h;
        abort         = ab;
        push_exp(ec, eb, ee, en);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [W-1:0] ec, input logic eb, input logic ee,
                        input logic [EW-1:0] en);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, ec, eb, ee, en);
    endtask

    // Monitor: compare the DUT against the queued expectation due this cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() > 0 && q[0].cyc == cycnt) begin
                exp_t e;
                e = q.pop_front();
                check_outputs("sb", e.cnt, e.busy, e.expire, e.n);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        if (!done) begin
            $display("FAIL watchdog: got timeout, expected end of stimulus");
            $fatal(1, "timeout");
        end
    end

    initial begin
        reset = 1'b1;
        load_valid = 1'b0; load_value = '0; load_periodic = 1'b0; hold = 1'b0; abort = 1'b0;
        #3;
        check_outputs("reset_init", '0, 1'b0, 1'b0, '0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        // One-shot load 5
        step(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 8'd5, 1'b1, 1'b0, 2'd0);
        idle(8'd4, 1'b1, 1'b0, 2'd0);
        idle(8'd3, 1'b1, 1'b0, 2'd0);
        idle(8'd2, 1'b1, 1'b0, 2'd0);
        idle(8'd1, 1'b1, 1'b0, 2'd0);
        idle(8'd0, 1'b0, 1'b1, 2'd1);
        idle(8'd0, 1'b0, 1'b0, 2'd1);

        // Periodic load 3 for 10 cycles, then abort
        step(1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 2'd0);
        idle(8'd2, 1'b1, 1'b0, 2'd0);
        idle(8'd1, 1'b1, 1'b0, 2'd0);
        idle(8'd3, 1'b1, 1'b1, 2'd1);
        idle(8'd2, 1'b1, 1'b0, 2'd1);
        idle(8'd1, 1'b1, 1'b0, 2'd1);
        idle(8'd3, 1'b1, 1'b1, 2'd2);
        idle(8'd2, 1'b1, 1'b0, 2'd2);
        idle(8'd1, 1'b1, 1'b0, 2'd2);
        idle(8'd3, 1'b1, 1'b1, 2'd3);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 2'd3);

        // Hold at cnt 2 for two cycles, then at cnt 1
        step(1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0, 2'd0);
        idle(8'd3, 1'b1, 1'b0, 2'd0);
        idle(8'd2, 1'b1, 1'b0, 2'd0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 8'd2, 1'b1, 1'b0, 2'd0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 8'd2, 1'b1, 1'b0, 2'd0);
        idle(8'd1, 1'b1, 1'b0, 2'd0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0, 2'd0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0, 2'd0);
        idle(8'd0, 1'b0, 1'b1, 2'd1);

        // Abort at terminal count, together with hold
        step(1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0, 2'd0);
        idle(8'd1, 1'b1, 1'b0, 2'd0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 2'd0);

        // Abort in IDLE has no effect; abort with load is ignored
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 2'd0);
        step(1'b1, 8'd2, 1'b0, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0, 2'd0);
        idle(8'd1, 1'b1, 1'b0, 2'd0);
        idle(8'd0, 1'b0, 1'b1, 2'd1);

        // Zero load in both modes
        step(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 2'd1);
        idle(8'd0, 1'b0, 1'b0, 2'd1);
        step(1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 2'd1);
        idle(8'd0, 1'b0, 1'b0, 2'd1);

        // Periodic load 1: expiry counter wraps; a load request in RUN is ignored
        step(1'b1, 8'd1, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0, 2'd0);
        idle(8'd1, 1'b1, 1'b1, 2'd1);
        step(1'b1, 8'd9, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 1'b1, 2'd2);
        idle(8'd1, 1'b1, 1'b1, 2'd3);
        idle(8'd1, 1'b1, 1'b1, 2'd0);
        idle(8'd1, 1'b1, 1'b1, 2'd1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 2'd1);

        // Reset mid-run at cnt 100
        step(1'b1, 8'd200, 1'b0, 1'b0, 1'b0, 8'd200, 1'b1, 1'b0, 2'd0);
        for (int i = 1; i <= 100; i++) idle(8'(200 - i), 1'b1, 1'b0, 2'd0);
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        check_outputs("reset_mid", '0, 1'b0, 1'b0, '0);
        @(posedge clk); #1;
        check_outputs("reset_held", '0, 1'b0, 1'b0, '0);
        @(negedge clk);
        reset = 1'b0;
        load_valid = 1'b1; load_value = 8'd1; load_periodic = 1'b0; hold = 1'b0; abort = 1'b0;
        push_exp(8'd1, 1'b1, 1'b0, 2'd0);
        @(posedge clk); #1;
        idle(8'd0, 1'b0, 1'b1, 2'd1);
        idle(8'd0, 1'b0, 1'b0, 2'd1);

        repeat (2) @(posedge clk);
        check("queue_drained", q.size(), 0);
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter: WIDTH, default 8, width of the count and load value.
REQ-002 Parameter: EXP_CNT_W, default 8, width of the expiry counter.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 load_valid  input  1  load request qualifier.
REQ-006 load_ready  output  1  high when a load can be accepted.
REQ-007 load_value  input  WIDTH  initial/reload count, sampled on accept.
REQ-008 load_periodic  input  1  mode, sampled on accept: 1 = periodic, 0 = one-shot.
REQ-009 hold  input  1  freezes the count while high.
REQ-010 abort  input  1  cancels a running countdown.
REQ-011 cnt_o  output  WIDTH  current remaining count, registered.
REQ-012 busy  output  1  high in RUN state, registered.
REQ-013 expire  output  1  one-cycle registered pulse at terminal count.
REQ-014 n_expired  output  EXP_CNT_W  expiries since last accepted load; wraps modulo 2^EXP_CNT_W.

Function
REQ-015 FSM states: IDLE and RUN only; busy SHALL equal (state == RUN).
REQ-016 load_ready SHALL be 1 in IDLE and 0 in RUN, combinational from state only.
REQ-017 Accept = load_valid & load_ready; on accept, the next cycle SHALL have: cnt_o = load_value, reload register = load_value, mode = load_periodic, n_expired = 0, state = RUN.
REQ-018 Accept with load_value == 0: next cycle cnt_o = 0, expire = 1, n_expired = 1, state = IDLE, regardless of mode.
REQ-019 RUN, hold = 0, cnt_o > 1: cnt_o decrements by 1 per cycle.
REQ-020 RUN, hold = 1: cnt_o, state and n_expired unchanged; expire = 0.
REQ-021 RUN, hold = 0, cnt_o == 1, one-shot: next cycle cnt_o = 0, state = IDLE, expire = 1, n_expired + 1.
REQ-022 RUN, hold = 0, cnt_o == 1, periodic: next cycle cnt_o = reload, state stays RUN, expire = 1, n_expired + 1; the period SHALL be exactly reload cycles.
REQ-023 expire SHALL be 0 in every cycle not named in REQ-018/021/022.
REQ-024 abort in RUN: next cycle state = IDLE, cnt_o = 0, expire = 0, n_expired unchanged; abort outranks hold and terminal count in the same cycle.
REQ-025 abort in IDLE: no effect; abort with load_valid in IDLE: load accepted, abort ignored.
REQ-026 IDLE without accept: cnt_o, n_expired hold their values.
REQ-027 n_expired wraps from 2^EXP_CNT_W-1 to 0 without side effects.
REQ-028 cnt_o SHALL never underflow; a decrement below 0 is unreachable.

Reset
REQ-029 reset asserted SHALL immediately force: state = IDLE, cnt_o = 0, reload = 0, mode = one-shot, busy = 0, expire = 0, n_expired = 0, load_ready = 1.
REQ-030 reset mid-countdown SHALL discard the countdown with no expire pulse; the first accept is possible in the first clk edge after deassertion.

Structure
REQ-031 Package countdown_timer_pkg SHALL hold the state enum (IDLE, RUN) and the default WIDTH/EXP_CNT_W constants.
REQ-032 Single module; no sub-module is required (the datapath is one decrementer plus a reload mux).

Verification
REQ-033 One-shot: load 5, hold = 0 -> busy for 5 cycles, cnt_o 5,4,3,2,1,0, expire once at cnt_o = 0, n_expired = 1, load_ready back to 1.
REQ-034 Periodic: load 3, run 10 cycles -> expire in cycles 3, 6 and 9 after accept, cnt_o sequence 3,2,1,3,2,1..., n_expired = 3.
REQ-035 Hold: load 4, hold high for 2 cycles at cnt_o = 2 -> cnt_o stays 2 for those cycles, expire delayed by 2 cycles; hold at cnt_o = 1 -> no expire until released.
REQ-036 Abort at terminal: load 2, assert abort when cnt_o = 1 -> next cycle cnt_o = 0, IDLE, expire = 0, n_expired = 0.
REQ-037 Zero load and wrap: load 0 -> expire next cycle, IDLE; with EXP_CNT_W = 2, periodic load 1, run 5 cycles -> n_expired 1,2,3,0,1.
REQ-038 Reset mid-run: load 200, assert reset at cnt_o = 100 -> outputs at reset values immediately, no expire; load 1 after release -> expire 1 cycle after accept.
